// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite rendering path: screen geometry,
//   the RGB565 colour key, the blitter FSM state type and the helper that
//   forms a sprite ROM address from (id, row, col, flip).
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t TRANSPARENT = 16'hF81F;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } blit_state_e;

   // ROM layout is {id, row, col}. A flipped sprite reads its columns
   // right-to-left so that screen pixels still come out left-to-right.
   // The result is 32 bits wide; callers truncate to their address width.
   function automatic logic [31:0] sprite_rom_addr(
      input logic [31:0] id,
      input logic [31:0] row,
      input logic [31:0] col,
      input logic        flip,
      input int          col_bits,
      input int          row_bits
   );
      logic [31:0] col_eff;
      col_eff = flip ? ((32'd1 << col_bits) - 32'd1 - col) : col;
      return (id << (col_bits + row_bits)) | (row << col_bits) | col_eff;
   endfunction

endpackage

// File: rtl/screen_clip.sv
// screen_clip
//   Combinational visibility test of a signed 12-bit screen coordinate
//   against the visible frame.
//   Ports:
//     x, y     in   signed 12-bit screen coordinate
//     visible  out  1 when 0 <= x < SCREEN_W and 0 <= y < SCREEN_H
module screen_clip #(
   parameter int SCREEN_W = sprite_pkg::SCREEN_W,
   parameter int SCREEN_H = sprite_pkg::SCREEN_H
) (
   input  logic signed [11:0] x,
   input  logic signed [11:0] y,
   output logic               visible
);

   // A clear sign bit means the value is non-negative, after which an
   // unsigned compare of the magnitude bits against the frame size suffices.
   assign visible = !x[11] && (x[10:0] < 11'(SCREEN_W)) &&
                    !y[11] && (y[10:0] < 11'(SCREEN_H));

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Accepts one sprite-draw request at a time, walks the sprite's pixels
//   out of a synchronous sprite ROM and emits one program beat per visible,
//   non-transparent pixel to the SRAM controller's program port.
//   Ports:
//     clk, reset            clock; synchronous active-low reset
//     req_valid/req_ready   draw request handshake (ready only when idle)
//     req_x, req_y          signed top-left screen position of the sprite
//     req_id, req_flip      sprite index and horizontal mirror
//     rom_addr, rom_data    sprite ROM port; data arrives one cycle after address
//     program_x/y/data      pixel coordinate and RGB565 colour
//     program_write         write strobe, one beat per pixel
//     program_ready         controller accepts the beat this cycle
//     busy                  a draw is in progress
//     done                  one-cycle pulse after the last pixel has retired
module sprite_blitter #(
   parameter int          SPRITE_W    = 32,
   parameter int          SPRITE_H    = 32,
   parameter int          ID_W        = 4,
   parameter int          SCREEN_W    = 640,
   parameter int          SCREEN_H    = 480,
   parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        req_valid,
   output logic                                        req_ready,
   input  logic signed [10:0]                          req_x,
   input  logic signed [10:0]                          req_y,
   input  logic [ID_W-1:0]                             req_id,
   input  logic                                        req_flip,
   output logic [ID_W+$clog2(SPRITE_W*SPRITE_H)-1:0]   rom_addr,
   input  logic [15:0]                                 rom_data,
   output logic [9:0]                                  program_x,
   output logic [9:0]                                  program_y,
   output logic [15:0]                                 program_data,
   output logic                                        program_write,
   input  logic                                        program_ready,
   output logic                                        busy,
   output logic                                        done
);
   import sprite_pkg::*;

   localparam int COL_W  = $clog2(SPRITE_W);
   localparam int ROW_W  = $clog2(SPRITE_H);
   localparam int ADDR_W = ID_W + COL_W + ROW_W;

   blit_state_e         state_reg;
   logic [ID_W-1:0]     id_reg;
   logic                flip_reg;
   logic signed [10:0]  x_reg;
   logic signed [10:0]  y_reg;
   logic [ROW_W-1:0]    row_reg;
   logic [COL_W-1:0]    col_reg;
   logic [ADDR_W-1:0]   last_addr_reg;
   logic                s1_valid_reg;
   logic signed [11:0]  s1_x_reg;
   logic signed [11:0]  s1_y_reg;
   logic                done_reg;

   logic                s1_visible;
   logic                stall;
   logic [ADDR_W-1:0]   issue_addr;

   screen_clip #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clip (
      .x       (s1_x_reg),
      .y       (s1_y_reg),
      .visible (s1_visible)
   );

   always_comb begin
      issue_addr = ADDR_W'(sprite_rom_addr(32'(id_reg), 32'(row_reg), 32'(col_reg),
                                           flip_reg, COL_W, ROW_W));
   end

   // Transparent or clipped pixels drop program_write, so they never stall.
   assign program_write = s1_valid_reg && (rom_data != TRANSPARENT) && s1_visible;
   assign stall         = program_write && !program_ready;

   // The counters already point at the next pixel while stage 1 waits, so
   // during a stall the ROM is re-driven with the address it read last
   // cycle (the stage-1 pixel); that keeps rom_data stable until the beat
   // is taken, and the cycle the stall clears the next pixel is issued.
   always_comb begin
      rom_addr = '0;
      if (stall) begin
         rom_addr = last_addr_reg;
      end else if (state_reg == ISSUE) begin
         rom_addr = issue_addr;
      end
   end

   assign program_x    = s1_x_reg[9:0];
   assign program_y    = s1_y_reg[9:0];
   assign program_data = s1_valid_reg ? rom_data : 16'h0000;
   assign req_ready    = (state_reg == IDLE);
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         id_reg        <= '0;
         flip_reg      <= 1'b0;
         x_reg         <= '0;
         y_reg         <= '0;
         row_reg       <= '0;
         col_reg       <= '0;
         last_addr_reg <= '0;
         s1_valid_reg  <= 1'b0;
         s1_x_reg      <= '0;
         s1_y_reg      <= '0;
         done_reg      <= 1'b0;
      end else begin
         done_reg      <= 1'b0;
         last_addr_reg <= rom_addr;

         // Stage 1 captures the screen position of the pixel being read.
         if (!stall) begin
            s1_valid_reg <= (state_reg == ISSUE);
            s1_x_reg     <= {x_reg[10], x_reg} + 12'(col_reg);
            s1_y_reg     <= {y_reg[10], y_reg} + 12'(row_reg);
         end

         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  id_reg    <= req_id;
                  flip_reg  <= req_flip;
                  x_reg     <= req_x;
                  y_reg     <= req_y;
                  row_reg   <= '0;
                  col_reg   <= '0;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  // Power-of-two dimensions let the counters wrap naturally.
                  col_reg <= col_reg + 1'b1;
                  if (col_reg == COL_W'(SPRITE_W - 1)) begin
                     row_reg <= row_reg + 1'b1;
                     if (row_reg == ROW_W'(SPRITE_H - 1)) begin
                        state_reg <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               // Only the final pixel can be in stage 1 here; once it is not
               // stalled it retires on this edge.
               if (!stall) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
//   Table-driven and randomized checks of sprite_blitter against a
//   pixel-walk reference model built from the draw rules.
module tb_sprite_blitter;

   localparam int          SW     = 32;
   localparam int          SH     = 32;
   localparam int          IDW    = 4;
   localparam int          AW     = IDW + 10;
   localparam logic [15:0] TRANSP = 16'hF81F;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic signed [10:0] req_x = '0;
   logic signed [10:0] req_y = '0;
   logic [IDW-1:0]     req_id = '0;
   logic               req_flip = 1'b0;
   logic [AW-1:0]      rom_addr;
   logic [15:0]        rom_data;
   logic [9:0]         program_x;
   logic [9:0]         program_y;
   logic [15:0]        program_data;
   logic               program_write;
   logic               program_ready = 1'b1;
   logic               busy;
   logic               done;

   sprite_blitter dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_x         (req_x),
      .req_y         (req_y),
      .req_id        (req_id),
      .req_flip      (req_flip),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .program_x     (program_x),
      .program_y     (program_y),
      .program_data  (program_data),
      .program_write (program_write),
      .program_ready (program_ready),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Synchronous sprite ROM.
   logic [15:0] rom_mem [0:(1<<AW)-1];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int x;
      int y;
      int d;
   } beat_t;

   beat_t got_q[$];
   beat_t exp_q[$];

   int accept_cyc = 0;
   int done_cnt   = 0;
   int done_cyc   = 0;
   int stall_cnt  = 0;
   int first_cyc  = -1;
   bit accepted   = 0;
   int ready_at_done = 0;
   int busy_at_done  = 0;
   int ready_mode = 0;
   int hold_start = 1 << 30;

   // Reference model: every sprite pixel in row-major screen order, dropped
   // when transparent or outside the 640x480 frame.
   task automatic build_expected(input int x, input int y, input int id, input bit flip);
      exp_q.delete();
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            int sx, sy, rc, d;
            sx = x + c;
            sy = y + r;
            rc = flip ? (SW - 1 - c) : c;
            d  = int'(rom_mem[id * SW * SH + r * SW + rc]);
            if (d != int'(TRANSP) && sx >= 0 && sx < 640 && sy >= 0 && sy < 480)
               exp_q.push_back('{sx, sy, d});
         end
      end
   endtask

   // program_ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       program_ready = ($urandom_range(0, 3) != 0);
            2:       program_ready = !(cyc >= hold_start && cyc < hold_start + 5);
            default: program_ready = 1'b1;
         endcase
      end
   end

   // Output monitor, sampled on the falling edge.
   initial begin
      logic       prev_stall;
      logic [9:0] px, py;
      logic [15:0] pd;
      prev_stall = 1'b0;
      px = '0;
      py = '0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (req_valid && req_ready) begin
               accepted   = 1;
               accept_cyc = cyc;
            end
            if (prev_stall) begin
               chk("stall_hold_xy", int'({program_x, program_y}), int'({px, py}));
               chk("stall_hold_wr_data", int'({program_write, program_data}), int'({1'b1, pd}));
            end
            if (program_write) begin
               if (first_cyc < 0) first_cyc = cyc;
               if (program_ready)
                  got_q.push_back('{int'(program_x), int'(program_y), int'(program_data)});
               else
                  stall_cnt++;
            end
            if (done) begin
               done_cnt++;
               done_cyc      = cyc;
               ready_at_done = int'(req_ready);
               busy_at_done  = int'(busy);
            end
            prev_stall = program_write && !program_ready;
            px = program_x;
            py = program_y;
            pd = program_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic start_draw(input int x, input int y, input int id, input bit flip, input int mode);
      build_expected(x, y, id, flip);
      got_q.delete();
      done_cnt   = 0;
      stall_cnt  = 0;
      first_cyc  = -1;
      accepted   = 0;
      hold_start = 1 << 30;
      ready_mode = mode;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_x     = 11'(x);
      req_y     = 11'(y);
      req_id    = IDW'(id);
      req_flip  = flip;
      for (int i = 0; i < 20 && !accepted; i++) @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("accept", int'(accepted), 1);
      hold_start = accept_cyc + 100;
   endtask

   task automatic finish_draw(input string name, input int exp_n, input int lat,
                              input int fx, input int fy, input int fd, input int exp_stall);
      int mism;
      int n;
      int exp_done;
      for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
      chk({name, "/done_seen"}, int'(done_cnt > 0), 1);
      repeat (4) @(posedge clk);
      chk({name, "/done_pulses"}, done_cnt, 1);
      if (exp_n >= 0) chk({name, "/beat_count"}, got_q.size(), exp_n);
      chk({name, "/model_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      mism = -1;
      for (int i = 0; i < n; i++) begin
         if (mism < 0 && (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y ||
                          got_q[i].d != exp_q[i].d))
            mism = i;
      end
      if (mism < 0 && got_q.size() != exp_q.size()) mism = n;
      chk({name, "/first_bad_beat"}, mism, -1);
      if (mism >= 0 && mism < n) begin
         chk({name, "/bad_beat_x"}, got_q[mism].x, exp_q[mism].x);
         chk({name, "/bad_beat_y"}, got_q[mism].y, exp_q[mism].y);
         chk({name, "/bad_beat_data"}, got_q[mism].d, exp_q[mism].d);
      end
      if (exp_n > 0 && got_q.size() > 0) begin
         chk({name, "/first_x"}, got_q[0].x, fx);
         chk({name, "/first_y"}, got_q[0].y, fy);
         chk({name, "/first_data"}, got_q[0].d, fd);
      end
      if (lat >= 0) chk({name, "/first_latency"}, first_cyc - accept_cyc, lat);
      exp_done = accept_cyc + SW * SH + 2 + ((exp_stall >= 0) ? exp_stall : stall_cnt);
      if (done_cnt > 0) begin
         chk({name, "/done_cycle"}, done_cyc, exp_done);
         chk({name, "/ready_at_done"}, ready_at_done, 1);
         chk({name, "/busy_at_done"}, busy_at_done, 0);
      end
      $display("draw %s: beats=%0d expected=%0d stalls=%0d accept=%0d done=%0d",
               name, got_q.size(), exp_q.size(), stall_cnt, accept_cyc, done_cyc);
   endtask

   typedef struct {
      string name;
      int    x;
      int    y;
      int    id;
      bit    flip;
      int    mode;
      int    exp_n;
      int    lat;
      int    fx;
      int    fy;
      int    fd;
      int    exp_stall;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ROM: sprite 0 opaque ramp, sprite 1 checkerboard, others random.
      for (int i = 0; i < SW * SH; i++) begin
         rom_mem[i] = 16'(16'h0400 + i);
         rom_mem[SW * SH + i] = (((i / SW) + (i % SW)) % 2 == 1) ? TRANSP : 16'(16'h1000 + i);
      end
      for (int i = 2 * SW * SH; i < (1 << AW); i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 16'($urandom);

      tbl[0] = '{"opaque",      100,  50, 0, 1'b0, 0, 1024,  2, 100,  50, 'h0400, 0};
      tbl[1] = '{"flip",        100,  50, 0, 1'b1, 0, 1024,  2, 100,  50, 'h041F, 0};
      tbl[2] = '{"clip_corner", -16, 470, 0, 1'b0, 0,  160, 18,   0, 470, 'h0410, 0};
      tbl[3] = '{"checker",      10,  10, 1, 1'b0, 0,  512,  2,  10,  10, 'h1000, 0};
      tbl[4] = '{"x639",        639,   0, 0, 1'b0, 0,   32,  2, 639,   0, 'h0400, 0};
      tbl[5] = '{"x640",        640,   0, 0, 1'b0, 0,    0, -1,   0,   0, 0,      0};
      tbl[6] = '{"neg_off",     -32, -32, 0, 1'b0, 0,    0, -1,   0,   0, 0,      0};
      tbl[7] = '{"bottom_flip",   0, 448, 0, 1'b1, 0, 1024,  2,   0, 448, 'h041F, 0};
      tbl[8] = '{"stall5",      100,  50, 0, 1'b0, 2, 1024,  2, 100,  50, 'h0400, 5};

      // Reset state.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #2;
      chk("reset/req_ready", int'(req_ready), 1);
      chk("reset/busy", int'(busy), 0);
      chk("reset/done", int'(done), 0);
      chk("reset/program_write", int'(program_write), 0);
      chk("reset/rom_addr", int'(rom_addr), 0);
      chk("reset/program_xy", int'({program_x, program_y}), 0);
      chk("reset/program_data", int'(program_data), 0);

      foreach (tbl[i]) begin
         start_draw(tbl[i].x, tbl[i].y, tbl[i].id, tbl[i].flip, tbl[i].mode);
         finish_draw(tbl[i].name, tbl[i].exp_n, tbl[i].lat, tbl[i].fx, tbl[i].fy,
                     tbl[i].fd, tbl[i].exp_stall);
      end

      // Randomized draws with random backpressure.
      for (int k = 0; k < 8; k++) begin
         int rx, ry, rid;
         bit rf;
         rx  = int'($urandom_range(0, 720)) - 40;
         ry  = int'($urandom_range(0, 560)) - 40;
         rid = int'($urandom_range(0, 15));
         rf  = 1'($urandom_range(0, 1));
         $display("random draw %0d: x=%0d y=%0d id=%0d flip=%0d", k, rx, ry, rid, rf);
         start_draw(rx, ry, rid, rf, 1);
         finish_draw("random", -1, -1, 0, 0, 0, -1);
      end

      // Reset in the middle of a draw.
      start_draw(200, 100, 0, 1'b0, 0);
      repeat (50) @(posedge clk);
      #1;
      chk("midreset/busy_before", int'(busy), 1);
      chk("midreset/req_ready_before", int'(req_ready), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      got_q.delete();
      #2;
      chk("midreset/program_write", int'(program_write), 0);
      chk("midreset/busy", int'(busy), 0);
      chk("midreset/req_ready", int'(req_ready), 1);
      chk("midreset/done", int'(done), 0);
      chk("midreset/rom_addr", int'(rom_addr), 0);
      repeat (1100) @(posedge clk);
      chk("midreset/no_done", done_cnt, 0);
      chk("midreset/no_writes", got_q.size(), 0);
      $display("reset mid-draw: writes after reset=%0d done pulses=%0d", got_q.size(), done_cnt);

      start_draw(5, 5, 0, 1'b1, 0);
      finish_draw("after_reset", 1024, 2, 5, 5, 'h041F, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Upstream feeder of sram_controller's program port.
- Accepts one sprite-draw request at a time: screen position, sprite ID and horizontal flip.
- Walks the sprite's pixels out of a synchronous sprite ROM and emits one program_x/program_y/program_data/program_write beat per visible, non-transparent pixel.
- Clips pixels that fall outside the 640x480 frame; the game logic queues draws through it each frame.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2).
- ID_W, 4, sprite ID width; the ROM holds 2^ID_W sprites.
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- TRANSPARENT, 16'hF81F, RGB565 colour key that is never written.

Ports:
- clk  in  1  system clock (same clock as the sram_controller program port).
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  draw request valid.
- req_ready  out  1  blitter can accept a request.
- req_x  in  11  signed top-left X of the sprite (-1024..1023).
- req_y  in  11  signed top-left Y of the sprite.
- req_id  in  ID_W  sprite index.
- req_flip  in  1  mirror horizontally.
- rom_addr  out  ID_W+log2(SPRITE_W*SPRITE_H)  sprite ROM address.
- rom_data  in  16  ROM pixel; valid exactly 1 cycle after rom_addr.
- program_x  out  10  pixel X to sram_controller.
- program_y  out  10  pixel Y to sram_controller.
- program_data  out  16  RGB565 pixel.
- program_write  out  1  write strobe; one beat per pixel.
- program_ready  in  1  sram_controller accepts the beat this cycle.
- busy  out  1  a draw is in progress.
- done  out  1  single-cycle pulse when the last pixel of a draw has retired.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; row/col counters clear; the pipeline valid bit clears.
  - Outputs: req_ready=1, busy=0, done=0, program_write=0, program_x/y/data=0, rom_addr=0.
  - An in-flight draw is abandoned with no further writes.
- Request handshake:
  - A request is accepted on a cycle where req_valid && req_ready.
  - req_x/y/id/flip are latched on acceptance.
  - req_ready=1 only in IDLE. There is no combinational path from req_valid to req_ready.
- FSM states IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE: on acceptance -> ISSUE with row=0, col=0.
  - ISSUE:
    - rom_addr = {id, row, flip ? SPRITE_W-1-col : col}.
    - Each cycle not stalled, advance col. On col wrap, advance row.
    - After issuing row=SPRITE_H-1, col=SPRITE_W-1 -> DRAIN.
  - DRAIN: wait until the pipeline stage is empty, then pulse done for 1 cycle (in the same cycle the state returns to IDLE). busy=0 from that cycle.
- Pipeline: two stages.
  - Stage 0: address issue.
  - Stage 1: a register holding screen X = req_x+col and Y = req_y+row (12-bit signed), plus a valid bit.
  - rom_data pairs with stage 1.
- Write rule:
  - program_write = s1_valid && rom_data != TRANSPARENT && 0 <= X < SCREEN_W && 0 <= Y < SCREEN_H.
  - program_x/y = X[9:0]/Y[9:0]; program_data = rom_data.
  - These outputs are combinational from the stage-1 register and rom_data (the ROM output is registered).
- Stall:
  - Condition: stall = s1_valid && program_write && !program_ready.
  - While stalled, rom_addr, counters and stage 1 hold. The ROM re-reads the same address, so rom_data stays stable.
  - Skipped pixels (transparent or clipped) never stall.
- Latency:
  - First beat appears 2 cycles after acceptance.
  - A fully visible, opaque, unstalled sprite takes SPRITE_W*SPRITE_H+2 cycles from acceptance to done.
- Boundaries:
  - A fully off-screen sprite still walks all pixels, writes nothing and still pulses done.
  - Negative coordinates clip correctly via signed compare.
  - X = 639 is visible; X = 640 is clipped.
- Simultaneous events: req_valid during DRAIN is not accepted (req_ready=0) and must be held by the requester.

Decomposition:
- Package sprite_pkg:
  - localparams SCREEN_W, SCREEN_H, TRANSPARENT.
  - typedef rgb565_t (16-bit).
  - typedef blit_state_e {IDLE, ISSUE, DRAIN}.
  - function sprite_rom_addr(id, row, col, flip).
- Sub-module screen_clip:
  - Combinational signed 12-bit X/Y against SCREEN_W/H -> visible.
  - Reused later by the bullet and zombie renderers.

Test Plan:
- Opaque sprite 0 (ROM value = 16'h0400 + index), req (100,50), program_ready=1 -> 1024 beats; first beat (100,50,16'h0400) 2 cycles after acceptance; last beat (131,81); done at cycle 1026; req_ready back to 1.
- Same sprite with req_flip=1 -> first beat (100,50) carries ROM col 31 data (16'h041F); beats stay in row-major screen order.
- req (-16,470) -> only X in 0..15 and Y in 470..479 written, i.e. 160 beats; done still pulses.
- Sprite with a checkerboard of TRANSPARENT pixels -> exactly 512 beats; no beat carries 16'hF81F.
- program_ready held low for 5 cycles mid-draw -> program_x/y/data/write held stable for those cycles; no beat lost or duplicated; done delayed by exactly 5 cycles.
- reset=0 asserted mid-ISSUE -> next cycle program_write=0, busy=0, req_ready=1; no done pulse; a new request afterwards draws correctly.
